// File: rtl/addr_seq_ctrl.sv
// Serial-number sequencer feeding the queue address selector: steps 0..LAST_SERIAL
// per tile, parks on IDLE_SERIAL while the array drains, and reports job progress.
module addr_seq_ctrl #(
  parameter int ARRAY_SIZE   = 8,
  parameter int QUEUE_COUNT  = (ARRAY_SIZE + 3) / 4,
  parameter int ADDR_OFFSET  = 4,
  parameter int ROW_LAST     = 98,
  parameter int DRAIN_CYCLES = 2 * ARRAY_SIZE,
  parameter int IDLE_SERIAL  = 127
) (
  input  logic       clk,
  input  logic       srstn,
  input  logic       start,
  input  logic [7:0] num_tiles,
  input  logic       stall,
  input  logic       abort,
  output logic [6:0] addr_serial_num,
  output logic       feed_valid,
  output logic       busy,
  output logic [7:0] tile_idx,
  output logic       tile_done,
  output logic       all_done,
  output logic [1:0] state_dbg
);

  localparam int LAST_SERIAL = ROW_LAST + (QUEUE_COUNT - 1) * ADDR_OFFSET;
  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [6:0] LAST_S = 7'(LAST_SERIAL);
  localparam logic [6:0] IDLE_S = 7'(IDLE_SERIAL);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);

  if (LAST_SERIAL > 126) begin : g_bad_last_serial
    $error("addr_seq_ctrl: LAST_SERIAL exceeds 126");
  end
  if (DRAIN_CYCLES < 1) begin : g_bad_drain
    $error("addr_seq_ctrl: DRAIN_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t         state;
  logic [DCW-1:0] drain_cnt;
  logic [7:0]     tiles_lat;

  assign state_dbg = state;

  // feed_valid has no ready: the selector must consume every cycle it is high,
  // and stall is the only back-pressure (serial holds, feed_valid drops).
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state           <= S_IDLE;
      addr_serial_num <= IDLE_S;
      feed_valid      <= 1'b0;
      busy            <= 1'b0;
      tile_idx        <= 8'd0;
      tile_done       <= 1'b0;
      all_done        <= 1'b0;
      drain_cnt       <= '0;
      tiles_lat       <= 8'd0;
    end else begin
      tile_done <= 1'b0;
      all_done  <= 1'b0;
      if (state != S_IDLE && abort) begin
        state           <= S_IDLE;
        addr_serial_num <= IDLE_S;
        feed_valid      <= 1'b0;
        busy            <= 1'b0;
        tile_idx        <= 8'd0;
        drain_cnt       <= '0;
        tiles_lat       <= 8'd0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              tiles_lat       <= (num_tiles == 8'd0) ? 8'd1 : num_tiles;
              tile_idx        <= 8'd0;
              addr_serial_num <= 7'd0;
              feed_valid      <= 1'b1;
              busy            <= 1'b1;
              state           <= S_FEED;
            end
          end
          S_FEED: begin
            if (stall) begin
              feed_valid <= 1'b0;
            end else if (addr_serial_num == LAST_S) begin
              state           <= S_DRAIN;
              addr_serial_num <= IDLE_S;
              feed_valid      <= 1'b0;
              drain_cnt       <= '0;
            end else begin
              addr_serial_num <= addr_serial_num + 7'd1;
              feed_valid      <= 1'b1;
            end
          end
          S_DRAIN: begin
            if (!stall) begin
              if (drain_cnt == DRAIN_LAST) begin
                tile_done <= 1'b1;
                drain_cnt <= '0;
                if (tile_idx == tiles_lat - 8'd1) begin
                  all_done <= 1'b1;
                  state    <= S_DONE;
                end else begin
                  // Next tile's first feed lands in the same cycle as tile_done.
                  tile_idx        <= tile_idx + 8'd1;
                  addr_serial_num <= 7'd0;
                  feed_valid      <= 1'b1;
                  state           <= S_FEED;
                end
              end else begin
                drain_cnt <= drain_cnt + 1'b1;
              end
            end
          end
          S_DONE: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/addr_seq_ctrl.md
Name: addr_seq_ctrl

Overview:
- Sequencer directly upstream of the queue address selector. Generates the 7-bit addr_serial_num stream that the selector turns into staggered weight/data SRAM read addresses.
- For each tile it steps the serial number 0..LAST_SERIAL, holds the idle sentinel while the systolic array drains, then moves to the next tile.
- Reports progress to the top-level controller through busy, per-tile and end-of-job pulses.

Parameters:
- ARRAY_SIZE, 8, systolic array dimension.
- QUEUE_COUNT, (ARRAY_SIZE+3)/4, number of staggered queues fed downstream.
- ADDR_OFFSET, 4, serial-number skew between consecutive queues.
- ROW_LAST, 98, last local address read by queue 0.
- DRAIN_CYCLES, 2*ARRAY_SIZE, cycles to wait after the last feed before a tile is complete.
- IDLE_SERIAL, 127, serial value driven when not feeding. Downstream maps it to ADDR_MAX.
- Derived: LAST_SERIAL = ROW_LAST + (QUEUE_COUNT-1)*ADDR_OFFSET. This is 102 at defaults.
- Elaboration check: LAST_SERIAL must be ≤ 126, otherwise $error. DRAIN_CYCLES must be ≥ 1.

Ports:
- clk  in  1  system clock, rising edge.
- srstn  in  1  asynchronous active-low reset.
- start  in  1  job start; sampled only in IDLE.
- num_tiles  in  8  tiles in the job; latched on an accepted start; 0 is treated as 1.
- stall  in  1  freeze the sequence; counters hold.
- abort  in  1  synchronous cancel; returns to IDLE next cycle.
- addr_serial_num  out  7  serial index to the address selector.
- feed_valid  out  1  high when addr_serial_num is a fresh, advancing feed value.
- busy  out  1  high in every state except IDLE.
- tile_idx  out  8  index of the current tile, starting at 0.
- tile_done  out  1  one-cycle pulse when a tile finishes.
- all_done  out  1  one-cycle pulse when the job finishes.

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, addr_serial_num=IDLE_SERIAL, feed_valid=0, busy=0, tile_idx=0, tile_done=0, all_done=0, drain_cnt=0, latched tile count=0.
- States: IDLE, FEED, DRAIN, DONE.
- IDLE:
  - start=1 at edge T: latch max(num_tiles,1), tile_idx=0, go to FEED.
  - Cycle T+1 shows addr_serial_num=0 with busy=1.
  - start in any other state is ignored.
- FEED:
  - stall=0: serial increments by 1 per cycle and feed_valid=1.
  - stall=1: serial holds and feed_valid=0.
  - At serial==LAST_SERIAL with stall=0: next cycle go to DRAIN, serial=IDLE_SERIAL, drain_cnt=0.
- DRAIN:
  - drain_cnt increments when stall=0 and holds when stall=1. feed_valid=0.
  - At drain_cnt==DRAIN_CYCLES-1 with stall=0: tile_done=1 next cycle.
  - If tile_idx == latched count-1: go to DONE.
  - Otherwise: tile_idx+1, go to FEED with serial=0. tile_done coincides with serial 0 of the next tile.
- DONE:
  - Lasts exactly one cycle with all_done=1, busy=1 and serial=IDLE_SERIAL.
  - Then IDLE with busy=0.
- Cycles per tile, no stalls: (LAST_SERIAL+1) + DRAIN_CYCLES.
- abort (highest priority, any state except IDLE): next cycle state IDLE with all outputs at reset values. No tile_done or all_done pulse.
- Simultaneous events:
  - abort and start in IDLE: abort is ignored and start is accepted.
  - stall together with the last-serial or last-drain condition: the transition is deferred until stall is low.
- Reset mid-operation: the asynchronous reset immediately forces reset values, and it applies regardless of clk.
- Width rules:
  - serial is 7-bit and never wraps; it stops at LAST_SERIAL.
  - tile_idx is 8-bit; the maximum job is 255 tiles.

Test Plan:
- Reset then idle: srstn low, then high, no start → addr_serial_num=127 and busy=0 forever; all pulses 0.
- Single tile, defaults: start at cycle 0 with num_tiles=1. Required response:
  - serial=0 at cycle 1 and 102 at cycle 103, with feed_valid=1 throughout.
  - serial=127 in cycles 104-119.
  - tile_done=1 and all_done=1 at cycle 120.
  - busy=0 from cycle 121.
- Multi-tile with num_tiles=3:
  - tile_done pulses at cycles 120, 239 and 358; serial=0 at cycles 1, 120 and 239.
  - tile_idx reads 0, 1, 2; all_done only at 358.
- Stalls: with num_tiles=1, hold stall for 5 cycles at serial=50 and 3 cycles at drain_cnt=15.
  - Serial holds at 50 with feed_valid=0 while stalled.
  - All later events shift by 8 cycles; all_done at cycle 128.
- Abort at serial=60: abort=1 → next cycle serial=127, busy=0, tile_idx=0, no pulses. A new start is accepted immediately.
- Edge cases:
  - num_tiles=0 behaves exactly like num_tiles=1.
  - start asserted during FEED is ignored.
  - srstn low asynchronously mid-DRAIN forces reset values before the next clk edge.
